cue_power_charger: RTL and testbench
====================================

Name: cue_power_charger

Overview:
- Upstream of the cue power bar renderer. Converts the player's charge key into a ping-pong power value that the bar displays, advancing once per video frame.
- On key release it latches the power and issues a one-cycle shot strobe to the cue/ball-launch logic.
- A cooldown follows each shot, and charging is blocked while balls are moving.

Parameters:
- MAX_POWER, 120, top of the power range; matches the bar's full 120-pixel interior.
- STEP, 2, power units added or removed per frame tick.
- MIN_SHOT, 4, minimum power for a valid shot; releasing below this cancels.
- COOLDOWN_FRAMES, 30, number of frame ticks after a shot during which the key is ignored.

Ports:
- clk, input, 1, system clock.
- resetN, input, 1, asynchronous active-low reset.
- startOfFrame, input, 1, one-clk pulse per VGA frame.
- chargeKey, input, 1, level, high while the charge key is held; already synchronous to clk.
- ballsMoving, input, 1, level, high while any ball has nonzero velocity.
- power, output, 32 (int), live power value 0..MAX_POWER; drives the bar.
- shotPower, output, 32 (int), power latched at the last shot; holds until the next shot.
- shotPulse, output, 1, one-clk strobe when a shot fires.
- charging, output, 1, high in CHARGE_UP and CHARGE_DOWN.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, resetN). Reset mid-operation returns to IDLE immediately with all outputs at reset values.
- Reset values: power=0, shotPower=0, shotPulse=0, charging=0, state=IDLE, cooldown counter=0.
- All outputs are registered. power changes on the clk edge after the qualifying startOfFrame cycle.
- IDLE:
  - power=0.
  - chargeKey=1 && ballsMoving=0 -> CHARGE_UP. The first increment comes at the next startOfFrame, not in the entry cycle.
- CHARGE_UP, on each startOfFrame:
  - power = min(power+STEP, MAX_POWER).
  - If the new value equals MAX_POWER -> CHARGE_DOWN.
- CHARGE_DOWN, on each startOfFrame:
  - power = max(power-STEP, 0).
  - If the new value equals 0 -> CHARGE_UP.
- Arithmetic is saturating; power never leaves 0..MAX_POWER. This holds even when STEP does not divide MAX_POWER.
- In either charge state, chargeKey=0 is sampled every clk:
  - power >= MIN_SHOT -> FIRE.
  - power < MIN_SHOT -> IDLE, power=0, no pulse.
- In either charge state, ballsMoving=1 -> IDLE, power=0, no pulse. This takes priority over key release.
- Simultaneous key release and startOfFrame: the release wins. power is not stepped, and the pre-step value is used for the shot.
- FIRE lasts exactly one cycle:
  - shotPulse=1 and shotPower=power on the same edge.
  - On the next edge: power=0, shotPulse=0, counter=0 -> COOLDOWN.
- COOLDOWN:
  - The counter increments on each startOfFrame; chargeKey and ballsMoving are ignored.
  - When the counter reaches COOLDOWN_FRAMES -> ARMWAIT.
- ARMWAIT:
  - Waits for chargeKey=0, then -> IDLE.
  - Charging never resumes from a key held across the cooldown; a fresh press is required.
- Illegal state encodings recover to IDLE with power=0.

Optional Feature:
- Macro: CUE_AUTOFIRE_EN.
- Defined: when CHARGE_UP reaches MAX_POWER, the block enters FIRE on the next edge instead of CHARGE_DOWN, with shotPower=MAX_POWER. CHARGE_DOWN is unreachable.
- Undefined: ping-pong behaviour as described above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset asserted mid-CHARGE_UP at power=40 -> all outputs 0 immediately (asynchronous); after release the block is in IDLE and power stays 0 across frames.
- Press key, 10 startOfFrame pulses, release -> power steps 2,4,..,20; exactly one shotPulse; shotPower=20; power=0 the cycle after the pulse.
- Hold key 61 frames (macro undefined) -> power=120 at frame 60 and 118 at frame 61, charging=1 throughout, no pulse. With CUE_AUTOFIRE_EN defined: shotPulse with shotPower=120 right after frame 60.
- Press, one frame (power=2), release -> no shotPulse, power=0, shotPower unchanged.
- Charge to 30, assert ballsMoving -> power=0 next cycle, no pulse, IDLE; a press while ballsMoving=1 keeps power=0.
- Fire, keep key held through the 30-frame cooldown plus 5 frames -> power stays 0 and no charge. Release, then press -> charging resumes from 0, and pressing during cooldown has no effect.

Source files
------------

// File: rtl/cue_power_charger.sv
// Charge-key to ping-pong cue power converter with shot strobe, cooldown and arm-wait.
// Optional build macro CUE_AUTOFIRE_EN: fire automatically when power reaches MAX_POWER.
module cue_power_charger #(
  parameter int MAX_POWER       = 120,
  parameter int STEP            = 2,
  parameter int MIN_SHOT        = 4,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        chargeKey,
  input  logic        ballsMoving,
  output logic [31:0] power,
  output logic [31:0] shotPower,
  output logic        shotPulse,
  output logic        charging,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CHARGE_UP   = 3'd1,
    CHARGE_DOWN = 3'd2,
    FIRE        = 3'd3,
    COOLDOWN    = 3'd4,
    ARMWAIT     = 3'd5
  } state_t;

  localparam logic [31:0] MAX_P  = 32'(MAX_POWER);
  localparam logic [31:0] STEP_P = 32'(STEP);
  localparam logic [31:0] MIN_P  = 32'(MIN_SHOT);
  localparam int          CW     = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CW-1:0] CD_LAST = CW'(COOLDOWN_FRAMES - 1);

  state_t        state_q;
  logic [31:0]   power_q;
  logic [31:0]   shot_power_q;
  logic          shot_pulse_q;
  logic          charging_q;
  logic [CW-1:0] cd_q;

  logic [31:0] up_d;
  logic [31:0] dn_d;

  // Saturating steps; comparisons are arranged so no intermediate can wrap.
  always_comb begin
    up_d = (power_q >= MAX_P - STEP_P) ? MAX_P : power_q + STEP_P;
    dn_d = (power_q <= STEP_P) ? 32'd0 : power_q - STEP_P;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      power_q      <= '0;
      shot_power_q <= '0;
      shot_pulse_q <= 1'b0;
      charging_q   <= 1'b0;
      cd_q         <= '0;
    end else begin
      shot_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          power_q <= '0;
          if (chargeKey && !ballsMoving) begin
            state_q    <= CHARGE_UP;
            charging_q <= 1'b1;
          end
        end
        CHARGE_UP, CHARGE_DOWN: begin
          // Ball motion beats key release, and release beats a same-cycle frame step.
          if (ballsMoving) begin
            state_q    <= IDLE;
            power_q    <= '0;
            charging_q <= 1'b0;
          end else if (!chargeKey) begin
            charging_q <= 1'b0;
            if (power_q >= MIN_P) begin
              state_q      <= FIRE;
              shot_pulse_q <= 1'b1;
              shot_power_q <= power_q;
            end else begin
              state_q <= IDLE;
              power_q <= '0;
            end
          end else if (startOfFrame) begin
            if (state_q == CHARGE_UP) begin
              power_q <= up_d;
              if (up_d == MAX_P) begin
`ifdef CUE_AUTOFIRE_EN
                state_q      <= FIRE;
                shot_pulse_q <= 1'b1;
                shot_power_q <= MAX_P;
                charging_q   <= 1'b0;
`else
                state_q <= CHARGE_DOWN;
`endif
              end
            end else begin
              power_q <= dn_d;
              if (dn_d == 32'd0) state_q <= CHARGE_UP;
            end
          end
        end
        FIRE: begin
          power_q <= '0;
          cd_q    <= '0;
          state_q <= COOLDOWN;
        end
        COOLDOWN: begin
          if (startOfFrame) begin
            cd_q <= cd_q + 1'b1;
            if (cd_q == CD_LAST) state_q <= ARMWAIT;
          end
        end
        ARMWAIT: begin
          if (!chargeKey) state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          power_q    <= '0;
          charging_q <= 1'b0;
        end
      endcase
    end
  end

  assign power     = power_q;
  assign shotPower = shot_power_q;
  assign shotPulse = shot_pulse_q;
  assign charging  = charging_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_cue_power_charger.sv
// Directed bench for cue_power_charger: charge, ping-pong, cancel, ball-motion abort, cooldown and arm-wait.
module tb_cue_power_charger;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        chargeKey;
  logic        ballsMoving;
  logic [31:0] power;
  logic [31:0] shotPower;
  logic        shotPulse;
  logic        charging;
  logic [2:0]  state_o;

  localparam logic [2:0] S_IDLE = 3'd0, S_UP = 3'd1, S_DOWN = 3'd2,
                         S_FIRE = 3'd3, S_COOL = 3'd4, S_ARM = 3'd5;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  int chg_low  = 0;

  cue_power_charger dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .chargeKey    (chargeKey),
    .ballsMoving  (ballsMoving),
    .power        (power),
    .shotPower    (shotPower),
    .shotPulse    (shotPulse),
    .charging     (charging),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  // Pulse count lags by one cycle: it sees the value held before each edge.
  always @(posedge clk) if (shotPulse) pulse_cnt <= pulse_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; chargeKey = 1'b0; ballsMoving = 1'b0;
    tick(2);
    check("rst_power", power, 0);
    check("rst_shotpower", shotPower, 0);
    check("rst_pulse", {31'd0, shotPulse}, 0);
    check("rst_charging", {31'd0, charging}, 0);
    check("rst_state", {29'd0, state_o}, S_IDLE);
    resetN = 1'b1;
    tick(1);

    // Async reset in the middle of CHARGE_UP at power 40
    chargeKey = 1'b1;
    tick(1);
    check("entry_state", {29'd0, state_o}, S_UP);
    check("entry_power", power, 0);
    repeat (20) frame();
    check("pre_reset_power", power, 40);
    #2 resetN = 1'b0;
    #1;
    check("async_power", power, 0);
    check("async_charging", {31'd0, charging}, 0);
    check("async_state", {29'd0, state_o}, S_IDLE);
    chargeKey = 1'b0;
    tick(1);
    resetN = 1'b1;
    repeat (3) frame();
    check("post_reset_power", power, 0);
    check("post_reset_state", {29'd0, state_o}, S_IDLE);

    // Ten frames then release: shot of 20
    chargeKey = 1'b1;
    tick(1);
    for (int i = 1; i <= 10; i++) begin
      frame();
      check("ramp_power", power, 32'(2 * i));
    end
    chargeKey = 1'b0;
    tick(1);
    check("fire_pulse", {31'd0, shotPulse}, 1);
    check("fire_shotpower", shotPower, 20);
    check("fire_state", {29'd0, state_o}, S_FIRE);
    tick(1);
    check("after_fire_power", power, 0);
    check("after_fire_pulse", {31'd0, shotPulse}, 0);
    check("after_fire_state", {29'd0, state_o}, S_COOL);
    check("pulse_once", pulse_cnt, 1);
    repeat (29) frame();
    check("cool_29_state", {29'd0, state_o}, S_COOL);
    frame();
    check("cool_30_state", {29'd0, state_o}, S_ARM);
    tick(1);
    check("arm_to_idle", {29'd0, state_o}, S_IDLE);

    // Hold for 61 frames: ping-pong at the top
    chargeKey = 1'b1;
    tick(1);
    chg_low = 0;
    for (int i = 1; i <= 61; i++) begin
      frame();
      if (!charging) chg_low++;
      if (i == 60) begin
        check("top_power", power, 120);
        check("top_state", {29'd0, state_o}, S_DOWN);
      end
    end
    check("pp_power_61", power, 118);
    check("pp_charging", chg_low, 0);
    check("pp_no_pulse", pulse_cnt, 1);
    ballsMoving = 1'b1;
    tick(1);
    check("pp_abort_power", power, 0);
    check("pp_abort_state", {29'd0, state_o}, S_IDLE);
    ballsMoving = 1'b0; chargeKey = 1'b0;
    tick(1);

    // Release below MIN_SHOT cancels
    chargeKey = 1'b1;
    tick(1);
    frame();
    check("short_power", power, 2);
    chargeKey = 1'b0;
    tick(1);
    check("short_pulse", {31'd0, shotPulse}, 0);
    check("short_power0", power, 0);
    check("short_state", {29'd0, state_o}, S_IDLE);
    check("short_shotpower_kept", shotPower, 20);

    // Ball motion abort at 30, and blocked press
    chargeKey = 1'b1;
    tick(1);
    repeat (15) frame();
    check("bm_pre_power", power, 30);
    ballsMoving = 1'b1;
    tick(1);
    check("bm_power", power, 0);
    check("bm_state", {29'd0, state_o}, S_IDLE);
    check("bm_charging", {31'd0, charging}, 0);
    repeat (2) frame();
    check("bm_blocked_power", power, 0);
    check("bm_blocked_state", {29'd0, state_o}, S_IDLE);
    check("bm_no_pulse", pulse_cnt, 1);
    ballsMoving = 1'b0; chargeKey = 1'b0;
    tick(1);

    // Key held across cooldown needs a fresh press
    chargeKey = 1'b1;
    tick(1);
    repeat (5) frame();
    chargeKey = 1'b0;
    tick(1);
    check("cd_fire_shotpower", shotPower, 10);
    chargeKey = 1'b1;
    tick(1);
    repeat (35) frame();
    check("cd_held_power", power, 0);
    check("cd_held_state", {29'd0, state_o}, S_ARM);
    check("cd_held_charging", {31'd0, charging}, 0);
    check("cd_pulse_cnt", pulse_cnt, 2);
    chargeKey = 1'b0;
    tick(1);
    check("cd_release_state", {29'd0, state_o}, S_IDLE);
    chargeKey = 1'b1;
    tick(1);
    frame();
    frame();
    check("cd_resume_power", power, 4);

    // Release in the same cycle as a frame: no step, shot at exactly MIN_SHOT
    chargeKey = 1'b0;
    frame();
    check("sim_pulse", {31'd0, shotPulse}, 1);
    check("sim_shotpower", shotPower, 4);
    tick(2);
    check("sim_pulse_cnt", pulse_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
